// File: rtl/sample_quantizer.sv
// Sample quantizer: fixed-latency binary search of a sample against a programmable ascending threshold table.
// Optional clip counter (clip_clr / clip_cnt) is compiled in when QUANT_CLIP_CNT_EN is defined.
module sample_quantizer #(
  parameter int DATA_W     = 12,
  parameter int LEVELS     = 10,
  parameter int QW         = 4,
  parameter int SRCH_ITERS = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [QW-1:0]     qlevel,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              th_we,
  input  logic [QW-1:0]     th_addr,
  input  logic [DATA_W-1:0] th_wdata,
  output logic              wr_drop
`ifdef QUANT_CLIP_CNT_EN
  ,
  input  logic              clip_clr,
  output logic [15:0]       clip_cnt
`endif
);

  localparam int NTH  = LEVELS - 1;
  localparam int STEP = (2 ** DATA_W) / LEVELS;
  localparam int CW   = $clog2(SRCH_ITERS + 1);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] th [NTH];
  logic [DATA_W-1:0] x;
  logic [QW-1:0]     lo, hi, mid, th_idx, lo_nxt, hi_nxt;
  logic [CW-1:0]     cnt;
  logic              search_done, th_ok;

  assign in_ready    = (state == IDLE);
  assign search_done = (state == SEARCH) && (cnt == CW'(SRCH_ITERS));
  assign th_ok       = in_ready && (th_addr < QW'(NTH));

  // One halving step; once lo==hi the interval is pinned so latency stays data independent.
  always_comb begin
    mid    = QW'((32'(lo) + 32'(hi) + 1) >> 1);
    th_idx = mid - QW'(1);
    lo_nxt = lo;
    hi_nxt = hi;
    if (lo < hi) begin
      if (x >= th[th_idx]) lo_nxt = mid;
      else                 hi_nxt = th_idx;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)    state_nxt = SEARCH;
      SEARCH:  if (search_done) state_nxt = DONE;
      DONE:    if (out_ready)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NTH; i++) th[i] <= DATA_W'((i + 1) * STEP);
      x         <= '0;
      lo        <= '0;
      hi        <= '0;
      cnt       <= '0;
      qlevel    <= '0;
      out_valid <= 1'b0;
      wr_drop   <= 1'b0;
    end else begin
      wr_drop <= th_we && !th_ok;
      // Write lands at the accept edge, so a coincident sample sees the new value.
      if (th_we && th_ok) th[th_addr] <= th_wdata;
      case (state)
        IDLE: if (in_valid) begin
          x   <= in_data;
          lo  <= '0;
          hi  <= QW'(LEVELS - 1);
          cnt <= '0;
        end
        SEARCH: if (search_done) begin
          qlevel    <= lo;
          out_valid <= 1'b1;
        end else begin
          lo  <= lo_nxt;
          hi  <= hi_nxt;
          cnt <= cnt + CW'(1);
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef QUANT_CLIP_CNT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      clip_cnt <= '0;
    else if (clip_clr)
      clip_cnt <= '0;
    else if (search_done && (lo == '0 || lo == QW'(LEVELS - 1)) && clip_cnt != 16'hFFFF)
      clip_cnt <= clip_cnt + 16'd1;
  end
`endif

endmodule
